// File: rtl/flash_line_fetcher_pkg.sv
// rtl/flash_line_fetcher_pkg.sv - shared states and AXI constants for the flash line fetcher
package flash_line_fetcher_pkg;

    typedef enum logic [2:0] {
        FLF_IDLE  = 3'd0,
        FLF_AR    = 3'd1,
        FLF_DATA  = 3'd2,
        FLF_DRAIN = 3'd3,
        FLF_RESP  = 3'd4
    } flf_state_e;

    localparam logic [1:0] AXI_BURST_INCR     = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY      = 2'b00;
    localparam logic [3:0] AXI_ID_FLASH_FETCH = 4'h0;
    localparam logic [3:0] AXI_CACHE_FETCH    = 4'b0011;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/flash_line_fetcher_if.sv
// rtl/flash_line_fetcher_if.sv - AXI4 read address/data channels between fetcher and flash slave
interface flash_line_fetcher_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/flash_line_fetcher.sv
// rtl/flash_line_fetcher.sv - single-outstanding AXI4 INCR line fill master for linear flash
module flash_line_fetcher
    import flash_line_fetcher_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 64,
    parameter int         LINE_BEATS = 8,
    parameter logic [3:0] AXI_ID     = AXI_ID_FLASH_FETCH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [DATA_W*LINE_BEATS-1:0] resp_line,
    output logic                         resp_err,
    flash_line_fetcher_if.master         axi
);

    localparam int LINE_BYTES = LINE_BEATS * DATA_W / 8;
    localparam int IDX_W      = $clog2(LINE_BEATS);
    localparam int CNT_W      = IDX_W + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

    flf_state_e        state_q;
    flf_state_e        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              err_q;
    logic [DATA_W-1:0] line_buf [LINE_BEATS];

    logic accept_req;
    logic data_beat;
    logic at_last;
    logic beat_bad;
    logic count_bad;
    logic arvalid_c;
    logic rready_c;

    assign at_last   = (beat_cnt == LAST_BEAT);
    assign data_beat = (state_q == FLF_DATA) && axi.rvalid;
    assign beat_bad  = (axi.rresp != AXI_RESP_OKAY) || (axi.rid != AXI_ID);
    // Early RLAST and a missing RLAST on the final slot are both framing errors.
    assign count_bad = axi.rlast != at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FLF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        arvalid_c  = 1'b0;
        rready_c   = 1'b0;
        resp_valid = 1'b0;
        accept_req = 1'b0;
        case (state_q)
            FLF_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept_req = 1'b1;
                    state_d    = FLF_AR;
                end
            end
            FLF_AR: begin
                arvalid_c = 1'b1;
                if (axi.arready) begin
                    state_d = FLF_DATA;
                end
            end
            FLF_DATA: begin
                rready_c = 1'b1;
                if (axi.rvalid) begin
                    if (axi.rlast) begin
                        state_d = FLF_RESP;
                    end else if (at_last) begin
                        state_d = FLF_DRAIN;
                    end
                end
            end
            FLF_DRAIN: begin
                // Overlong burst: keep accepting until the slave closes it.
                rready_c = 1'b1;
                if (axi.rvalid && axi.rlast) begin
                    state_d = FLF_RESP;
                end
            end
            FLF_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = FLF_IDLE;
                end
            end
            default: begin
                state_d = FLF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            for (int k = 0; k < LINE_BEATS; k++) begin
                line_buf[k] <= '0;
            end
        end else begin
            if (accept_req) begin
                addr_q   <= req_addr & ~LINE_MASK;
                beat_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (data_beat) begin
                line_buf[beat_cnt[IDX_W-1:0]] <= axi.rdata;
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_bad || count_bad) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < LINE_BEATS; k++) begin : g_pack
        assign resp_line[k*DATA_W +: DATA_W] = line_buf[k];
    end

    assign resp_err = err_q;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(LINE_BEATS - 1);
    assign axi.arsize  = axi_size(DATA_W);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = AXI_CACHE_FETCH;
    assign axi.arprot  = 3'b000;
    assign axi.arqos   = 4'b0000;
    assign axi.arvalid = arvalid_c;
    assign axi.rready  = rready_c;

endmodule

// File: tb/tb_flash_line_fetcher.sv
// tb/tb_flash_line_fetcher.sv - directed self-checking bench for flash_line_fetcher
module tb_flash_line_fetcher;
    import flash_line_fetcher_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int LINE_BEATS = 8;
    localparam int LINE_W     = DATA_W * LINE_BEATS;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_line;
    logic              resp_err;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [DATA_W-1:0] exp_buf [LINE_BEATS];

    always #5 clk = ~clk;

    flash_line_fetcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    flash_line_fetcher #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LINE_BEATS(LINE_BEATS),
        .AXI_ID    (4'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_line (resp_line),
        .resp_err  (resp_err),
        .axi       (axi)
    );

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] exp_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_BEATS; k++) begin
            l[k*DATA_W +: DATA_W] = exp_buf[k];
        end
        return l;
    endfunction

    task automatic ar_phase(input logic [ADDR_W-1:0] addr, input int hold);
        logic [ADDR_W-1:0] aligned;
        aligned = addr & ~32'h0000_003F;
        check("idle_no_arvalid", axi.arvalid, 1'b0);
        check("req_ready_idle", req_ready, 1'b1);
        req_addr  = addr;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("arvalid", axi.arvalid, 1'b1);
        check("araddr", axi.araddr, aligned);
        check("arlen", axi.arlen, 8'd7);
        check("arsize", axi.arsize, 3'd3);
        check("arburst", axi.arburst, 2'b01);
        check("arid", axi.arid, 4'h0);
        check("arcache", axi.arcache, 4'b0011);
        check("arlock_prot_qos", {axi.arlock, axi.arprot, axi.arqos}, 8'h00);
        check("req_ready_busy", req_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("arvalid_hold", axi.arvalid, 1'b1);
            check("araddr_hold", axi.araddr, aligned);
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        check("arvalid_drop", axi.arvalid, 1'b0);
    endtask

    task automatic send_beats(input logic [DATA_W-1:0] seed, input int n, input int last_at,
                              input int bad_resp_at, input int bad_id_at);
        for (int k = 0; k < n; k++) begin
            check("rready_burst", axi.rready, 1'b1);
            check("no_resp_in_burst", resp_valid, 1'b0);
            axi.rvalid = 1'b1;
            axi.rdata  = seed * 64'(k + 1);
            axi.rresp  = (k == bad_resp_at) ? 2'b10 : 2'b00;
            axi.rid    = (k == bad_id_at) ? 4'h5 : 4'h0;
            axi.rlast  = (k == last_at);
            if (k < LINE_BEATS) exp_buf[k] = seed * 64'(k + 1);
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        axi.rid    = 4'h0;
    endtask

    task automatic take_resp(input logic err, input int hold, input logic req_during);
        logic [LINE_W-1:0] line;
        line = exp_line();
        check("resp_valid", resp_valid, 1'b1);
        check("resp_line", resp_line, line);
        check("resp_err", resp_err, err);
        check("rready_resp", axi.rready, 1'b0);
        if (req_during) req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("resp_valid_hold", resp_valid, 1'b1);
            check("resp_line_hold", resp_line, line);
            check("resp_err_hold", resp_err, err);
            check("req_ready_in_resp", req_ready, 1'b0);
            check("no_arvalid_in_resp", axi.arvalid, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_done", resp_valid, 1'b0);
        check("idle_after_resp", req_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        resp_ready  = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rid     = 4'h0;
        axi.rlast   = 1'b0;
        for (int k = 0; k < LINE_BEATS; k++) exp_buf[k] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_line", resp_line, '0);

        // basic aligned fill, 0x11..0x88
        ar_phase(32'h0000_0124, 0);
        send_beats(64'h11, 8, 7, -1, -1);
        check("t1_line_const", resp_line[127:0], 128'h0000000000000022_0000000000000011);
        take_resp(1'b0, 0, 1'b0);

        // ARREADY stalled 20 cycles
        ar_phase(32'h1234_5678, 20);
        send_beats(64'h0101_0101_0000_0001, 8, 7, -1, -1);
        take_resp(1'b0, 0, 1'b0);

        // SLVERR on beat 3, then RID mismatch on beat 2
        ar_phase(32'h0000_2000, 0);
        send_beats(64'h0202_0000_0000_0003, 8, 7, 3, -1);
        take_resp(1'b1, 0, 1'b0);
        ar_phase(32'h0000_3040, 0);
        send_beats(64'h0303_0000_0000_0005, 8, 7, -1, 2);
        take_resp(1'b1, 0, 1'b0);

        // early RLAST on beat 5: slots 6,7 keep previous line
        ar_phase(32'h0000_4080, 0);
        send_beats(64'h0404_0000_0000_0007, 6, 5, -1, -1);
        take_resp(1'b1, 0, 1'b0);

        // 12-beat burst, 4 drained
        ar_phase(32'h0000_50C0, 0);
        send_beats(64'h0505_0000_0000_0009, 12, 11, -1, -1);
        take_resp(1'b1, 0, 1'b0);

        // clean fill, response stalled 10 cycles with a new request pending
        ar_phase(32'h0000_6000, 0);
        send_beats(64'h0606_0000_0000_000B, 8, 7, -1, -1);
        take_resp(1'b0, 10, 1'b1);
        ar_phase(32'h0000_7000, 0);
        send_beats(64'h0707_0000_0000_000D, 8, 7, -1, -1);
        take_resp(1'b0, 0, 1'b0);

        // reset asserted while beat 4 is on the bus
        ar_phase(32'h2000_0040, 0);
        send_beats(64'h0808_0000_0000_000F, 4, -1, -1, -1);
        axi.rvalid = 1'b1;
        axi.rdata  = 64'hDEAD_BEEF_0000_0004;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_arvalid", axi.arvalid, 1'b0);
        check("mid_rst_rready", axi.rready, 1'b0);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_resp_err", resp_err, 1'b0);
        check("mid_rst_resp_line", resp_line, '0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst        = 1'b0;
        axi.rvalid = 1'b0;
        for (int k = 0; k < LINE_BEATS; k++) exp_buf[k] = '0;
        @(negedge clk);
        ar_phase(32'h2000_0080, 0);
        send_beats(64'h0909_0000_0000_0011, 8, 7, -1, -1);
        take_resp(1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
